// File: rtl/gpu_pkg.sv
// Shared types and constants for the layer address generation stage.
// The descriptor struct is 49 bits: enable, layerId, and four coordinates.
package gpu_pkg;

  localparam int NUM_LAYERS = 64;
  localparam int COORD_W    = 10;
  localparam int IDX_W      = 6;
  localparam int CNT_W      = 7;
  localparam int ADDR_W     = 25;

  typedef struct packed {
    logic               en;
    logic [7:0]         layerId;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } layer_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/layer_hit_calc.sv
// Combinational coverage test and byte offset for one layer descriptor.
// Right/bottom edges use one extra bit so x0+w cannot wrap.
module layer_hit_calc
  import gpu_pkg::*;
(
  input  layer_desc_t        desc,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               hit,
  output logic [ADDR_W-1:0]  offset
);

  localparam int LIN_W = 2 * COORD_W + 1;

  logic [COORD_W:0]   x_end;
  logic [COORD_W:0]   y_end;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [LIN_W-1:0]   lin;

  assign x_end = {1'b0, desc.x0} + {1'b0, desc.w};
  assign y_end = {1'b0, desc.y0} + {1'b0, desc.h};

  assign hit = desc.en
             && (desc.w != '0) && (desc.h != '0)
             && (px >= desc.x0) && ({1'b0, px} < x_end)
             && (py >= desc.y0) && ({1'b0, py} < y_end);

  assign dx = px - desc.x0;
  assign dy = py - desc.y0;

  // Two bytes per pixel, so the linear index is shifted left by one.
  assign lin    = LIN_W'(dy) * LIN_W'(desc.w) + LIN_W'(dx);
  assign offset = ADDR_W'({lin, 1'b0});

endmodule

// File: rtl/layer_addr_gen.sv
// Scans the layer descriptor table for each accepted pixel and issues one
// layer RAM read per covering layer, in ascending slot order.
//
// state | meaning
// IDLE  | accept descriptor writes or a new pixel
// SCAN  | test slot[cnt] against the latched pixel
// ISSUE | hold read request until ram_rdy
// WAIT  | wait for RAM idle before next slot
// DONE  | one-cycle px_done pulse
module layer_addr_gen
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               desc_we,
  input  logic [IDX_W-1:0]   desc_idx,
  input  logic               desc_en,
  input  logic [7:0]         desc_layerId,
  input  logic [COORD_W-1:0] desc_x0,
  input  logic [COORD_W-1:0] desc_y0,
  input  logic [COORD_W-1:0] desc_w,
  input  logic [COORD_W-1:0] desc_h,
  input  logic [CNT_W-1:0]   num_layers,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               ram_rdy,
  output logic               pipe_read_en,
  output logic [IDX_W-1:0]   pipe_layer,
  output logic [7:0]         pipe_layerId,
  output logic [ADDR_W-1:0]  pipe_addr_bytes,
  output logic               px_done,
  output logic               busy
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [COORD_W-1:0] lat_x, lat_y;
  logic [CNT_W-1:0]   lat_num;
  logic               load_pix, load_req;

  layer_desc_t        desc_tbl [NUM_LAYERS];
  layer_desc_t        cur;
  logic               cur_hit;
  logic [ADDR_W-1:0]  cur_off;

  assign cur     = desc_tbl[cnt[IDX_W-1:0]];
  assign cnt_inc = cnt + CNT_W'(1);

  layer_hit_calc u_hit (
    .desc   (cur),
    .px     (lat_x),
    .py     (lat_y),
    .hit    (cur_hit),
    .offset (cur_off)
  );

  assign pix_ready    = (state == ST_IDLE) && !desc_we;
  assign pipe_read_en = (state == ST_ISSUE);
  assign px_done      = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_pix  = 1'b0;
    load_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pix_valid && pix_ready) begin
          load_pix  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // The cnt==lat_num test only fires for an empty scan (num_layers=0).
        if (cnt == lat_num) begin
          state_nxt = ST_DONE;
        end else if (cur_hit) begin
          load_req  = 1'b1;
          state_nxt = ST_ISSUE;
        end else if (cnt_inc == lat_num) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_ISSUE: begin
        if (ram_rdy) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ram_rdy) begin
          if (cnt_inc == lat_num) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt   = cnt_inc;
            state_nxt = ST_SCAN;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_x           <= '0;
      lat_y           <= '0;
      lat_num         <= '0;
      pipe_layer      <= '0;
      pipe_layerId    <= '0;
      pipe_addr_bytes <= '0;
    end else begin
      if (load_pix) begin
        lat_x   <= pix_x;
        lat_y   <= pix_y;
        lat_num <= num_layers;
      end
      if (load_req) begin
        pipe_layer      <= cnt[IDX_W-1:0];
        pipe_layerId    <= cur.layerId;
        pipe_addr_bytes <= cur_off;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) desc_tbl[i] <= '0;
    end else if (desc_we && (state == ST_IDLE)) begin
      desc_tbl[desc_idx] <= '{en: desc_en, layerId: desc_layerId,
                              x0: desc_x0, y0: desc_y0,
                              w: desc_w, h: desc_h};
    end
  end

endmodule

// File: tb/tb_layer_addr_gen.sv
// Randomized scoreboard bench for layer_addr_gen: a spec-level model queues
// expected requests and px_done events, an independent monitor checks them.
module tb_layer_addr_gen;
  import gpu_pkg::*;

  logic               clk = 0;
  logic               rst = 1;
  logic               desc_we = 0;
  logic [IDX_W-1:0]   desc_idx = '0;
  logic               desc_en = 0;
  logic [7:0]         desc_layerId = '0;
  logic [COORD_W-1:0] desc_x0 = '0, desc_y0 = '0, desc_w = '0, desc_h = '0;
  logic [CNT_W-1:0]   num_layers = '0;
  logic               pix_valid = 0;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x = '0, pix_y = '0;
  logic               ram_rdy = 0;
  logic               pipe_read_en;
  logic [IDX_W-1:0]   pipe_layer;
  logic [7:0]         pipe_layerId;
  logic [ADDR_W-1:0]  pipe_addr_bytes;
  logic               px_done;
  logic               busy;

  layer_addr_gen dut (
    .clk(clk), .rst(rst), .desc_we(desc_we), .desc_idx(desc_idx),
    .desc_en(desc_en), .desc_layerId(desc_layerId), .desc_x0(desc_x0),
    .desc_y0(desc_y0), .desc_w(desc_w), .desc_h(desc_h),
    .num_layers(num_layers), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .ram_rdy(ram_rdy),
    .pipe_read_en(pipe_read_en), .pipe_layer(pipe_layer),
    .pipe_layerId(pipe_layerId), .pipe_addr_bytes(pipe_addr_bytes),
    .px_done(px_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit done;
    int layer;
    int id;
    int addr;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   rdy_mode = 2;  // 0 random, 1 low, 2 high

  int m_en[64], m_id[64], m_x0[64], m_y0[64], m_w[64], m_h[64];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // Expected traffic for one pixel, straight from the coverage rules.
  task automatic model_pixel(input int x, input int y, input int n);
    exp_t e;
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      if (m_en[i] != 0 && m_w[i] > 0 && m_h[i] > 0 &&
          x >= m_x0[i] && x < m_x0[i] + m_w[i] &&
          y >= m_y0[i] && y < m_y0[i] + m_h[i]) begin
        e.done  = 0;
        e.layer = i;
        e.id    = m_id[i];
        e.addr  = ((y - m_y0[i]) * m_w[i] + (x - m_x0[i])) * 2;
        e.lat   = -1;
        exp_q.push_back(e);
        hits++;
      end
    end
    e.done  = 1;
    e.layer = 0;
    e.id    = 0;
    e.addr  = 0;
    e.lat   = (hits != 0) ? -1 : ((n == 0) ? 2 : n + 1);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) fail_now("wait_idle");
  endtask

  task automatic write_desc(input int idx, input int en, input int id,
                            input int x0, input int y0, input int w, input int h);
    wait_idle();
    @(posedge clk); #1;
    desc_we = 1; desc_idx = IDX_W'(idx); desc_en = 1'(en);
    desc_layerId = 8'(id); desc_x0 = COORD_W'(x0); desc_y0 = COORD_W'(y0);
    desc_w = COORD_W'(w); desc_h = COORD_W'(h);
    @(posedge clk); #1;
    desc_we = 0;
    m_en[idx] = en; m_id[idx] = id; m_x0[idx] = x0;
    m_y0[idx] = y0; m_w[idx] = w; m_h[idx] = h;
  endtask

  // Returns one time unit after the accepting clock edge.
  task automatic send_pixel(input int x, input int y, input int n);
    bit ok = 0;
    model_pixel(x, y, n);
    @(posedge clk); #1;
    pix_x = COORD_W'(x); pix_y = COORD_W'(y);
    num_layers = CNT_W'(n); pix_valid = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (pix_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("pix_accept");
    @(posedge clk); #1;
    pix_valid = 0;
  endtask

  task automatic wait_read_en();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pipe_read_en) begin ok = 1; break; end
    end
    if (!ok) fail_now("wait_read_en");
  endtask

  initial begin : rdy_drv
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ram_rdy = ($urandom_range(0, 2) != 0);
        1: ram_rdy = 0;
        default: ram_rdy = 1;
      endcase
    end
  end

  initial begin : monitor
    int cyc = 0;
    int acc_cyc = 0;
    bit prev_en = 0, prev_rdy = 0;
    logic [IDX_W-1:0]  prev_layer = '0;
    logic [7:0]        prev_id = '0;
    logic [ADDR_W-1:0] prev_addr = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_en = 0;
        continue;
      end
      if (pix_valid && pix_ready) acc_cyc = cyc;
      if (prev_en && !prev_rdy)
        chk("issue_hold",
            longint'({pipe_read_en, pipe_layer, pipe_layerId, pipe_addr_bytes}),
            longint'({1'b1, prev_layer, prev_id, prev_addr}));
      if (pipe_read_en && ram_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req_layer", longint'(pipe_layer), -1);
        end else begin
          e = exp_q.pop_front();
          chk("req_kind", longint'(e.done), 0);
          chk("req_layer", longint'(pipe_layer), longint'(e.layer));
          chk("req_layerId", longint'(pipe_layerId), longint'(e.id));
          chk("req_addr", longint'(pipe_addr_bytes), longint'(e.addr));
        end
      end
      if (px_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_kind", longint'(e.done), 1);
          if (e.lat >= 0) chk("done_latency", longint'(cyc - acc_cyc), longint'(e.lat));
        end
      end
      prev_en    = pipe_read_en;
      prev_rdy   = ram_rdy;
      prev_layer = pipe_layer;
      prev_id    = pipe_layerId;
      prev_addr  = pipe_addr_bytes;
    end
  end

  initial begin : stim
    for (int i = 0; i < 64; i++) begin
      m_en[i] = 0; m_id[i] = 0; m_x0[i] = 0; m_y0[i] = 0; m_w[i] = 0; m_h[i] = 0;
    end
    #1;
    chk("rst_read_en", longint'(pipe_read_en), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_px_done", longint'(px_done), 0);
    chk("rst_pix_ready", longint'(pix_ready), 1);
    chk("rst_fields", longint'({pipe_layer, pipe_layerId, pipe_addr_bytes}), 0);
    repeat (3) @(negedge clk);
    rst = 0;

    // Single slot, interior and edge pixels.
    rdy_mode = 2;
    write_desc(3, 1, 'h21, 10, 20, 100, 50);
    send_pixel(15, 22, 4);
    send_pixel(109, 69, 4);
    send_pixel(110, 20, 4);
    send_pixel(10, 70, 4);

    // Back-pressure: request must stay frozen while ram_rdy is low.
    wait_idle();
    rdy_mode = 1;
    send_pixel(15, 22, 4);
    wait_read_en();
    repeat (10) @(negedge clk);
    rdy_mode = 2;

    // Far corner: x0+w exceeds the coordinate range.
    write_desc(10, 1, 'h5a, 1000, 1000, 1023, 1023);
    send_pixel(1023, 1023, 11);

    // Multi-layer ordering over all 64 slots.
    write_desc(0, 1, 'h01, 0, 0, 8, 8);
    write_desc(5, 1, 'h05, 0, 0, 3, 5);
    write_desc(63, 1, 'h3f, 0, 0, 40, 2);
    send_pixel(0, 0, 64);

    // Disabled and empty layers covering the pixel, and an empty scan.
    write_desc(7, 0, 'h77, 200, 200, 10, 10);
    write_desc(8, 1, 'h88, 200, 200, 0, 10);
    write_desc(9, 1, 'h99, 200, 200, 10, 0);
    send_pixel(202, 203, 12);
    send_pixel(15, 22, 0);

    // Randomized descriptors and pixels with a random ram_rdy.
    rdy_mode = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        write_desc($urandom_range(0, 15), ($urandom_range(0, 3) != 0) ? 1 : 0,
                   $urandom_range(0, 255), $urandom_range(0, 40), $urandom_range(0, 40),
                   $urandom_range(0, 30), $urandom_range(0, 30));
      send_pixel($urandom_range(0, 63), $urandom_range(0, 63),
                 ($urandom_range(0, 4) == 0) ? 64 : $urandom_range(0, 20));
    end

    // Descriptor writes during SCAN must be dropped.
    rdy_mode = 2;
    write_desc(3, 1, 'h21, 10, 20, 100, 50);
    send_pixel(15, 22, 64);
    desc_we = 1; desc_idx = 6'd3; desc_en = 1; desc_layerId = 8'hee;
    desc_x0 = '0; desc_y0 = '0; desc_w = 10'd5; desc_h = 10'd5;
    @(posedge clk); #1;
    chk("pix_ready_busy", longint'(pix_ready), 0);
    @(posedge clk); #1;
    desc_we = 0;
    send_pixel(15, 22, 4);

    // Reset while a request is pending.
    wait_idle();
    rdy_mode = 1;
    send_pixel(15, 22, 4);
    wait_read_en();
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("arst_read_en", longint'(pipe_read_en), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_fields", longint'({pipe_layer, pipe_layerId, pipe_addr_bytes}), 0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) m_en[i] = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    rdy_mode = 2;
    send_pixel(15, 22, 4);
    send_pixel(0, 0, 64);

    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
